// File: rtl/memory_controller_pkg.sv
// Shared types and default geometry for the main-memory controller, bank and cache.
package mem_pkg;

  localparam int MEMORY_DATA_WIDTH    = 256;
  localparam int MEMORY_ADDRESS_WIDTH = 2;
  localparam int MEMORY_LATENCY       = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/memory_controller_if.sv
// Cache-side request/response channel of the memory controller.
interface memory_controller_if #(
  parameter int DATA_WIDTH = mem_pkg::MEMORY_DATA_WIDTH,
  parameter int ADDR_WIDTH = mem_pkg::MEMORY_ADDRESS_WIDTH
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_write, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_data
  );

endinterface

// File: rtl/memory_controller.sv
// Fixed-latency whole-line memory controller; one request in flight, drives a memory_bank.
//   state | meaning
//   IDLE  | ready for a request
//   BUSY  | request held on the bank ports while the latency counter runs down
//   RESP  | response presented until the requester takes it
module memory_controller
  import mem_pkg::*;
#(
  parameter int MEMORY_DATA_WIDTH    = mem_pkg::MEMORY_DATA_WIDTH,
  parameter int MEMORY_ADDRESS_WIDTH = mem_pkg::MEMORY_ADDRESS_WIDTH,
  parameter int MEMORY_LATENCY       = mem_pkg::MEMORY_LATENCY
) (
  input  logic                            clk,
  input  logic                            reset,
  memory_controller_if.slave              bus,
  output logic                            mem_write,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_in,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_out,
  output logic [MEMORY_DATA_WIDTH-1:0]    mem_data_in,
  input  logic [MEMORY_DATA_WIDTH-1:0]    mem_data_out
);

  localparam int CNT_W = $clog2(MEMORY_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEMORY_LATENCY - 1);

  mem_state_t                      state;
  logic [CNT_W-1:0]                cnt;
  logic                            cap_write;
  logic [MEMORY_ADDRESS_WIDTH-1:0] cap_addr;
  logic [MEMORY_DATA_WIDTH-1:0]    cap_data;
  logic                            rsp_write_q;
  logic [MEMORY_DATA_WIDTH-1:0]    rsp_data_q;
  logic                            busy;
  logic                            last_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cap_write   <= 1'b0;
      cap_addr    <= '0;
      cap_data    <= '0;
      rsp_write_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cap_write <= bus.req_write;
            cap_addr  <= bus.req_addr;
            cap_data  <= bus.req_data;
            cnt       <= CNT_LOAD;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            // Read data is sampled here, after the address has been stable for the full latency.
            rsp_data_q  <= cap_write ? cap_data : mem_data_out;
            rsp_write_q <= cap_write;
            state       <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == BUSY);
  assign last_busy = busy && (cnt == '0);

  // Gated by reset so the requester never sees ready while the block is held in reset.
  assign bus.req_ready = (state == IDLE) && reset;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_data  = rsp_data_q;

  assign mem_write    = last_busy && cap_write;
  assign mem_addr_in  = busy ? cap_addr : '0;
  assign mem_addr_out = busy ? cap_addr : '0;
  assign mem_data_in  = busy ? cap_data : '0;

endmodule

// File: tb/tb_memory_controller.sv
// Self-checking bench: memory_controller driving a behavioural 4-line memory bank.
module tb_memory_controller;
  import mem_pkg::*;

  localparam int DW  = 256;
  localparam int AW  = 2;
  localparam int LAT = 5;
  localparam int CW  = DW + 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic          mem_write;
  logic [AW-1:0] mem_addr_in;
  logic [AW-1:0] mem_addr_out;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;

  memory_controller #(
    .MEMORY_DATA_WIDTH(DW),
    .MEMORY_ADDRESS_WIDTH(AW),
    .MEMORY_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus),
    .mem_write(mem_write),
    .mem_addr_in(mem_addr_in),
    .mem_addr_out(mem_addr_out),
    .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  // Bank: synchronous write, combinational read, not cleared by the controller reset.
  logic [DW-1:0] bank [4] = '{default: '0};
  always @(posedge clk) if (mem_write) bank[mem_addr_in] <= mem_data_in;
  assign mem_data_out = bank[mem_addr_out];

  int cycle     = 0;
  int wr_pulses = 0;
  int accepts[$];
  always @(posedge clk) cycle <= cycle + 1;
  always @(negedge clk) if (mem_write) wr_pulses <= wr_pulses + 1;
  always @(posedge clk) if (rst && bus.req_valid && bus.req_ready) accepts.push_back(cycle);

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] model [4] = '{default: '0};

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_d;
    logic          exp_w;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_accept(input int n0, output bit got);
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (accepts.size() > n0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      if (bus.rsp_valid) begin
        lat = k - 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_req(input string name, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp_d, input logic exp_w);
    int  n0, p0, lat;
    bit  got;
    p0 = wr_pulses;
    n0 = accepts.size();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_data  = d;
    wait_accept(n0, got);
    bus.req_valid = 1'b0;
    if (!got) begin
      check({name, "_accept_timeout"}, CW'(0), CW'(1));
      return;
    end
    check({name, "_bank_ports"}, CW'({mem_addr_in, mem_addr_out, mem_data_in}), CW'({a, a, d}));
    wait_rsp(lat);
    check({name, "_latency"}, CW'(lat), CW'(LAT));
    if (lat < 0) return;
    check({name, "_rsp_data"}, CW'(bus.rsp_data), CW'(exp_d));
    check({name, "_rsp_write"}, CW'(bus.rsp_write), CW'(exp_w));
    @(posedge clk);
    #1;
    check({name, "_write_pulses"}, CW'(wr_pulses - p0), CW'(w ? 1 : 0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n0, p0, lat;
    bit  got;
    logic [DW-1:0] held;

    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;

    tbl[0] = '{w: 1'b1, a: 2'd1, d: 256'd4, exp_d: 256'd4, exp_w: 1'b1};
    tbl[1] = '{w: 1'b0, a: 2'd1, d: 256'd0, exp_d: 256'd4, exp_w: 1'b0};
    tbl[2] = '{w: 1'b0, a: 2'd3, d: 256'd0, exp_d: 256'd0, exp_w: 1'b0};
    tbl[3] = '{w: 1'b1, a: 2'd0, d: 256'h5a5a, exp_d: 256'h5a5a, exp_w: 1'b1};
    tbl[4] = '{w: 1'b0, a: 2'd0, d: 256'd0, exp_d: 256'h5a5a, exp_w: 1'b0};

    // Reset state: everything low, ready included.
    bus.req_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          CW'({bus.req_ready, bus.rsp_valid, bus.rsp_write, bus.rsp_data,
               mem_write, mem_addr_in, mem_addr_out, mem_data_in}), CW'(0));
    check("reset_no_accept", CW'(accepts.size()), CW'(0));
    bus.req_valid = 1'b0;
    rst = 1'b1;

    foreach (tbl[i]) begin
      do_req($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp_d, tbl[i].exp_w);
      if (tbl[i].w) model[tbl[i].a] = tbl[i].d;
    end

    // Response backpressure with a second request already waiting.
    bus.rsp_ready = 1'b0;
    n0 = accepts.size();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 2'd1;
    wait_accept(n0, got);
    check("bp_accept", CW'(got), CW'(1));
    bus.req_write = 1'b1;
    bus.req_addr  = 2'd3;
    bus.req_data  = 256'h55;
    wait_rsp(lat);
    check("bp_latency", CW'(lat), CW'(LAT));
    held = model[1];
    for (int j = 0; j < 3; j++) begin
      if (j > 0) @(negedge clk);
      check($sformatf("bp_hold%0d", j), CW'({bus.rsp_valid, bus.req_ready, bus.rsp_data}),
            CW'({1'b1, 1'b0, held}));
    end
    check("bp_no_early_accept", CW'(accepts.size()), CW'(n0 + 1));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_after_handshake", CW'({bus.rsp_valid, bus.req_ready}), CW'(2'b01));
    check("bp_not_on_handshake", CW'(accepts.size()), CW'(n0 + 1));
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("bp_second_accept", CW'(accepts.size()), CW'(n0 + 2));
    check("bp_second_addr", CW'(mem_addr_in), CW'(3));
    wait_rsp(lat);
    check("bp_second_rsp", CW'({bus.rsp_write, bus.rsp_data}), CW'({1'b1, 256'h55}));
    @(posedge clk);
    model[3] = 256'h55;

    // Reset on the third BUSY cycle of a write: abandoned, never committed.
    p0 = wr_pulses;
    n0 = accepts.size();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 2'd2;
    bus.req_data  = 256'haa;
    wait_accept(n0, got);
    bus.req_valid = 1'b0;
    check("rst_mid_accept", CW'(got), CW'(1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_outputs",
          CW'({bus.req_ready, bus.rsp_valid, bus.rsp_write, bus.rsp_data,
               mem_write, mem_addr_in, mem_addr_out, mem_data_in}), CW'(0));
    repeat (6) @(negedge clk);
    check("rst_mid_no_pulse", CW'(wr_pulses - p0), CW'(0));
    rst = 1'b1;
    do_req("rst_mid_readback", 1'b0, 2'd2, '0, model[2], 1'b0);

    // Back-to-back writes with valid held high: accepts exactly seven cycles apart.
    p0 = wr_pulses;
    n0 = accepts.size();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 2'd0;
    bus.req_data  = 256'h10;
    for (int i = 0; i < 4; i++) begin
      wait_accept(n0 + i, got);
      check($sformatf("b2b_accept%0d", i), CW'(got), CW'(1));
      if (!got) break;
      bus.req_addr = AW'(i + 1);
      bus.req_data = DW'(32'h11 + i);
    end
    bus.req_valid = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 1; i < 4; i++) begin
      if (accepts.size() > n0 + i)
        check($sformatf("b2b_spacing%0d", i), CW'(accepts[n0 + i] - accepts[n0 + i - 1]), CW'(7));
    end
    check("b2b_pulses", CW'(wr_pulses - p0), CW'(4));
    for (int i = 0; i < 4; i++) model[i] = DW'(32'h10 + i);
    for (int i = 0; i < 4; i++)
      do_req($sformatf("b2b_read%0d", i), 1'b0, AW'(i), '0, DW'(32'h10 + i), 1'b0);

    // Random traffic against the line-store model.
    for (int i = 0; i < 24; i++) begin
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 3));
      for (int b = 0; b < DW / 32; b++) d[b*32 +: 32] = $urandom;
      do_req($sformatf("rnd%0d", i), w, a, d, w ? d : model[a], w);
      if (w) model[a] = d;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
